// File: rtl/vlane_store_packer.sv
`timescale 1ns/1ps
// vlane_store_packer
//   Store-data packer between the vector lanes and the AXI write stream.
//   It takes one element group per lane handshake, where element k comes
//   from lane k. It then packs the SEW-sized elements, in element order,
//   into OUT_W-wide beats, one element per cycle. Each beat carries byte
//   strobes, and the beat holding element vl-1 carries tlast.
//
//   Optional feature: define VLANE_STORE_MASK_EN to add lane_mask_i.
//   A masked element keeps its byte slot, but its data and strobes are
//   zero.
//
//   Ports
//     clk_i, rst_i            clock, synchronous active-high reset
//     start_i, sew_i, vl_i    transfer start (sampled in IDLE), element width, element count
//     busy_o, done_o          not-IDLE flag, one-cycle completion pulse
//     lane_data_i/_valid_i    element group (lane k at [32k+31:32k])
//     lane_mask_i             per-element enable (VLANE_STORE_MASK_EN only)
//     lane_ready_o            group ready
//     wr_t*                   AXI-stream style write beat output
//
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | accepting groups and packing elements
//   DRAIN | last beat loaded, waiting for its handshake
module vlane_store_packer #(
    parameter int VLANE_NUM = 4,
    parameter int OUT_W     = 64,
    parameter int VL_W      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [1:0]             sew_i,
    input  logic [VL_W-1:0]        vl_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic [VLANE_NUM*32-1:0] lane_data_i,
`ifdef VLANE_STORE_MASK_EN
    input  logic [VLANE_NUM-1:0]   lane_mask_i,
`endif
    input  logic                   lane_valid_i,
    output logic                   lane_ready_o,
    output logic [OUT_W-1:0]       wr_tdata_o,
    output logic [OUT_W/8-1:0]     wr_tstrb_o,
    output logic                   wr_tvalid_o,
    output logic                   wr_tlast_o,
    input  logic                   wr_tready_i
);
    localparam int OB = OUT_W / 8;
    localparam int OW = $clog2(OB);
    localparam int CW = $clog2(VLANE_NUM + 1);
    localparam int IW = (VLANE_NUM > 1) ? $clog2(VLANE_NUM) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state_q, state_nx;

    logic [1:0]             sew_q;
    logic [VL_W-1:0]        rem_q;      // elements not yet taken into a group
    logic [VLANE_NUM*32-1:0] grp_data_q;
    logic [CW-1:0]          grp_cnt_q;  // live elements still to pack from the group
    logic [IW-1:0]          grp_idx_q;
`ifdef VLANE_STORE_MASK_EN
    logic [VLANE_NUM-1:0]   grp_mask_q;
`endif
    logic [OUT_W-1:0]       acc_data_q, acc_data_nx;
    logic [OB-1:0]          acc_strb_q, acc_strb_nx;
    logic [OW-1:0]          off_q;
    logic [OUT_W-1:0]       out_data_q;
    logic [OB-1:0]          out_strb_q;
    logic                   out_valid_q, out_last_q, done_q;

    logic [2:0]             size;
    logic [OW:0]            off_sum;
    logic [OW-1:0]          bidx;
    logic [31:0]            elem;
    logic                   elem_en, elem_close, last_elem, pack_en, out_hs, out_free, accept;
    logic [CW-1:0]          live;

    // Packing datapath
    always_comb begin
        size       = 3'd1 << sew_q;
        off_sum    = {1'b0, off_q} + (OW+1)'(size);
        last_elem  = (grp_cnt_q == CW'(1)) && (rem_q == '0);
        elem_close = (off_sum == (OW+1)'(OB)) || last_elem;
        out_hs     = out_valid_q && wr_tready_i;
        out_free   = !out_valid_q || wr_tready_i;
        // The closing element goes straight to the output register, so it
        // may only pack when that register can take it.
        pack_en    = (state_q == RUN) && (grp_cnt_q != '0) && (!elem_close || out_free);
        accept     = lane_valid_i && lane_ready_o;
        live       = (rem_q < VL_W'(VLANE_NUM)) ? CW'(rem_q) : CW'(VLANE_NUM);
        elem       = grp_data_q[grp_idx_q*32 +: 32];
`ifdef VLANE_STORE_MASK_EN
        elem_en    = grp_mask_q[grp_idx_q];
`else
        elem_en    = 1'b1;
`endif
        acc_data_nx = acc_data_q;
        acc_strb_nx = acc_strb_q;
        bidx        = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < size) begin
                bidx = off_q + OW'(b);
                acc_data_nx[bidx*8 +: 8] = elem_en ? elem[b*8 +: 8] : 8'h00;
                acc_strb_nx[bidx]        = elem_en;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (start_i && (vl_i != '0))   state_nx = RUN;
            RUN:     if (pack_en && last_elem)      state_nx = DRAIN;
            DRAIN:   if (out_hs && out_last_q)      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_o       = (state_q != IDLE);
        // rem_q != 0 keeps a spare group from being taken after the final one.
        lane_ready_o = (state_q == RUN) && (rem_q != '0) &&
                       ((grp_cnt_q == '0) || ((grp_cnt_q == CW'(1)) && pack_en));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sew_q       <= '0;
            rem_q       <= '0;
            grp_data_q  <= '0;
            grp_cnt_q   <= '0;
            grp_idx_q   <= '0;
`ifdef VLANE_STORE_MASK_EN
            grp_mask_q  <= '0;
`endif
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            off_q       <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == IDLE) && start_i) begin
                sew_q      <= (sew_i == 2'd3) ? 2'd2 : sew_i;
                rem_q      <= vl_i;
                off_q      <= '0;
                acc_data_q <= '0;
                acc_strb_q <= '0;
                if (vl_i == '0) done_q <= 1'b1;
            end
            if ((state_q == DRAIN) && out_hs && out_last_q) done_q <= 1'b1;

            if (accept) begin
                grp_data_q <= lane_data_i;
`ifdef VLANE_STORE_MASK_EN
                grp_mask_q <= lane_mask_i;
`endif
                grp_idx_q  <= '0;
                grp_cnt_q  <= live;
                rem_q      <= rem_q - VL_W'(live);
            end else if (pack_en) begin
                grp_cnt_q  <= grp_cnt_q - CW'(1);
                grp_idx_q  <= grp_idx_q + IW'(1);
            end

            if (pack_en) begin
                if (elem_close) begin
                    out_data_q <= acc_data_nx;
                    out_strb_q <= acc_strb_nx;
                    out_last_q <= last_elem;
                    acc_data_q <= '0;
                    acc_strb_q <= '0;
                    off_q      <= '0;
                end else begin
                    acc_data_q <= acc_data_nx;
                    acc_strb_q <= acc_strb_nx;
                    off_q      <= off_sum[OW-1:0];
                end
            end

            if (pack_en && elem_close) out_valid_q <= 1'b1;
            else if (out_hs)           out_valid_q <= 1'b0;
        end
    end

    assign done_o      = done_q;
    assign wr_tdata_o  = out_data_q;
    assign wr_tstrb_o  = out_strb_q;
    assign wr_tvalid_o = out_valid_q;
    assign wr_tlast_o  = out_last_q;
endmodule

// File: tb/tb_vlane_store_packer.sv
`timescale 1ns/1ps
module tb_vlane_store_packer;
    logic         clk_i = 1'b0;
    logic         rst_i, start_i, lane_valid_i, wr_tready_i;
    logic [1:0]   sew_i;
    logic [15:0]  vl_i;
    logic [127:0] lane_data_i;
    logic [3:0]   lane_mask_i;
    logic         busy_o, done_o, lane_ready_o, wr_tvalid_o, wr_tlast_o;
    logic [63:0]  wr_tdata_o;
    logic [7:0]   wr_tstrb_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    vlane_store_packer #(.VLANE_NUM(4), .OUT_W(64), .VL_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sew_i(sew_i), .vl_i(vl_i),
        .busy_o(busy_o), .done_o(done_o), .lane_data_i(lane_data_i),
`ifdef VLANE_STORE_MASK_EN
        .lane_mask_i(lane_mask_i),
`endif
        .lane_valid_i(lane_valid_i), .lane_ready_o(lane_ready_o),
        .wr_tdata_o(wr_tdata_o), .wr_tstrb_o(wr_tstrb_o), .wr_tvalid_o(wr_tvalid_o),
        .wr_tlast_o(wr_tlast_o), .wr_tready_i(wr_tready_i)
    );

    typedef struct {
        logic [1:0]        sew;
        int                vl;
        logic [3:0][127:0] grp;
        logic [3:0]        mask;
        int                stall_at;
        int                stall_len;
        int                nbeats;
        logic [7:0][63:0]  exp_data;
        logic [7:0][7:0]   exp_strb;
    } vec_t;

`ifdef VLANE_STORE_MASK_EN
    localparam int NV = 6;
`else
    localparam int NV = 5;
`endif
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] sew, input int vl, input int nbeats);
        vec_t v;
        v.sew = sew; v.vl = vl; v.nbeats = nbeats;
        v.grp = '0; v.mask = 4'hF; v.stall_at = 0; v.stall_len = 0;
        v.exp_data = '0; v.exp_strb = '0;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},   {63'd0, busy_o},       64'd0);
        chk({tag, "_done"},   {63'd0, done_o},       64'd0);
        chk({tag, "_lready"}, {63'd0, lane_ready_o}, 64'd0);
        chk({tag, "_tvalid"}, {63'd0, wr_tvalid_o},  64'd0);
        chk({tag, "_tlast"},  {63'd0, wr_tlast_o},   64'd0);
        chk({tag, "_tdata"},  wr_tdata_o,            64'd0);
        chk({tag, "_tstrb"},  {56'd0, wr_tstrb_o},   64'd0);
    endtask

    // Runs one transfer; abort_beat>=0 asserts reset while that beat is presented.
    task automatic run_vec(input vec_t v, input int idx, input int abort_beat);
        int gi, nb, ngrp, done_cyc, last_cyc;
        logic stall_prev;
        logic [63:0] pd;
        logic [7:0]  ps;
        logic        pl;
        string tag;
        tag = $sformatf("v%0d", idx);
        gi = 0; nb = 0; done_cyc = -1; last_cyc = -100; stall_prev = 1'b0;
        pd = '0; ps = '0; pl = 1'b0;
        ngrp = (v.vl + 3) / 4;
        @(negedge clk_i);
        start_i = 1'b1; sew_i = v.sew; vl_i = 16'(v.vl);
        @(negedge clk_i);
        start_i = 1'b0;
        #1 chk({tag, "_busy_run"}, {63'd0, busy_o}, 64'd1);
        for (int cyc = 0; cyc < 300; cyc++) begin
            lane_valid_i = (gi < ngrp);
            lane_data_i  = (gi < ngrp) ? v.grp[gi] : '0;
            lane_mask_i  = v.mask;
            wr_tready_i  = !(cyc >= v.stall_at && cyc < v.stall_at + v.stall_len);
            #1;
            if (abort_beat >= 0 && nb == abort_beat && wr_tvalid_o) begin
                rst_i = 1'b1; wr_tready_i = 1'b0; lane_valid_i = 1'b0;
                @(posedge clk_i);
                #1 check_idle_outputs({tag, "_midrst"});
                @(negedge clk_i);
                rst_i = 1'b0;
                return;
            end
            if (stall_prev) begin
                chk({tag, "_hold_data"}, wr_tdata_o, pd);
                chk({tag, "_hold_strb"}, {56'd0, wr_tstrb_o}, {56'd0, ps});
                chk({tag, "_hold_last"}, {63'd0, wr_tlast_o}, {63'd0, pl});
            end
            if (v.stall_len > 0 && cyc == v.stall_at + v.stall_len - 1)
                chk({tag, "_lready_stall"}, {63'd0, lane_ready_o}, 64'd0);
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            if (lane_valid_i && lane_ready_o) gi++;
            if (wr_tvalid_o && wr_tready_i) begin
                if (nb < v.nbeats) begin
                    chk($sformatf("%s_b%0d_data", tag, nb), wr_tdata_o, v.exp_data[nb]);
                    chk($sformatf("%s_b%0d_strb", tag, nb), {56'd0, wr_tstrb_o}, {56'd0, v.exp_strb[nb]});
                    chk($sformatf("%s_b%0d_last", tag, nb), {63'd0, wr_tlast_o},
                        (nb == v.nbeats - 1) ? 64'd1 : 64'd0);
                end else begin
                    chk($sformatf("%s_extra_beat", tag), 64'd1, 64'd0);
                end
                if (wr_tlast_o) last_cyc = cyc;
                nb++;
            end
            stall_prev = wr_tvalid_o && !wr_tready_i;
            pd = wr_tdata_o; ps = wr_tstrb_o; pl = wr_tlast_o;
            @(negedge clk_i);
        end
        lane_valid_i = 1'b0;
        wr_tready_i  = 1'b1;
        chk({tag, "_done_seen"}, {63'd0, (done_cyc >= 0)}, 64'd1);
        chk({tag, "_nbeats"}, 64'(nb), 64'(v.nbeats));
        chk({tag, "_ngroups"}, 64'(gi), 64'(ngrp));
        chk({tag, "_done_lat"}, 64'(done_cyc - last_cyc), 64'd1);
        @(negedge clk_i);
        #1;
        chk({tag, "_done_pulse"}, {63'd0, done_o}, 64'd0);
        chk({tag, "_busy_end"},   {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; sew_i = '0; vl_i = '0;
        lane_data_i = '0; lane_mask_i = 4'hF; lane_valid_i = 1'b0; wr_tready_i = 1'b1;

        // v0: sew=32b, vl=4, one group {D,C,B,A}
        vecs[0] = mk(2'd2, 4, 2);
        vecs[0].grp[0] = {32'hD1D2D3D4, 32'hC1C2C3C4, 32'hB1B2B3B4, 32'hA1A2A3A4};
        vecs[0].exp_data[0] = 64'hB1B2B3B4_A1A2A3A4; vecs[0].exp_strb[0] = 8'hFF;
        vecs[0].exp_data[1] = 64'hD1D2D3D4_C1C2C3C4; vecs[0].exp_strb[1] = 8'hFF;
        // v1: sew=8b, vl=5, upper lane bits are junk and must not appear
        vecs[1] = mk(2'd0, 5, 1);
        vecs[1].grp[0] = {32'hEEEEEE13, 32'hEEEEEE12, 32'hEEEEEE11, 32'hEEEEEE10};
        vecs[1].grp[1] = {32'hEEEEEE17, 32'hEEEEEE16, 32'hEEEEEE15, 32'hEEEEEE14};
        vecs[1].exp_data[0] = 64'h00000014_13121110; vecs[1].exp_strb[0] = 8'h1F;
        // v2: sew=32b, vl=16, tready low 10 cycles mid-stream
        vecs[2] = mk(2'd2, 16, 8);
        vecs[2].stall_at = 5; vecs[2].stall_len = 10;
        vecs[2].grp[0] = {32'h30000003, 32'h30000002, 32'h30000001, 32'h30000000};
        vecs[2].grp[1] = {32'h30000007, 32'h30000006, 32'h30000005, 32'h30000004};
        vecs[2].grp[2] = {32'h3000000B, 32'h3000000A, 32'h30000009, 32'h30000008};
        vecs[2].grp[3] = {32'h3000000F, 32'h3000000E, 32'h3000000D, 32'h3000000C};
        vecs[2].exp_data[0] = 64'h30000001_30000000;
        vecs[2].exp_data[1] = 64'h30000003_30000002;
        vecs[2].exp_data[2] = 64'h30000005_30000004;
        vecs[2].exp_data[3] = 64'h30000007_30000006;
        vecs[2].exp_data[4] = 64'h30000009_30000008;
        vecs[2].exp_data[5] = 64'h3000000B_3000000A;
        vecs[2].exp_data[6] = 64'h3000000D_3000000C;
        vecs[2].exp_data[7] = 64'h3000000F_3000000E;
        vecs[2].exp_strb = {8{8'hFF}};
        // v3: sew=16b, vl=6
        vecs[3] = mk(2'd1, 6, 2);
        vecs[3].grp[0] = {32'h55554003, 32'h55554002, 32'h55554001, 32'h55554000};
        vecs[3].grp[1] = {32'h55554007, 32'h55554006, 32'h55554005, 32'h55554004};
        vecs[3].exp_data[0] = 64'h4003400240014000; vecs[3].exp_strb[0] = 8'hFF;
        vecs[3].exp_data[1] = 64'h0000000040054004; vecs[3].exp_strb[1] = 8'h0F;
        // v4: sew code 3 behaves as 32b, vl=2
        vecs[4] = mk(2'd3, 2, 1);
        vecs[4].grp[0] = {32'h77777777, 32'h66666666, 32'h9ABCDEF0, 32'h12345678};
        vecs[4].exp_data[0] = 64'h9ABCDEF0_12345678; vecs[4].exp_strb[0] = 8'hFF;
`ifdef VLANE_STORE_MASK_EN
        // v5: mask 0101 on the v0 group
        vecs[5] = vecs[0];
        vecs[5].mask = 4'b0101;
        vecs[5].exp_data[0] = 64'h00000000_A1A2A3A4; vecs[5].exp_strb[0] = 8'h0F;
        vecs[5].exp_data[1] = 64'h00000000_C1C2C3C4; vecs[5].exp_strb[1] = 8'h0F;
`endif

        repeat (3) @(negedge clk_i);
        #1 check_idle_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i, -1);

        // vl=0: single done pulse, nothing else moves
        @(negedge clk_i);
        start_i = 1'b1; vl_i = 16'd0; sew_i = 2'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        chk("vl0_done", {63'd0, done_o}, 64'd1);
        chk("vl0_busy", {63'd0, busy_o}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            #1;
            chk($sformatf("vl0_done_c%0d", k), {63'd0, done_o}, 64'd0);
            chk($sformatf("vl0_busy_c%0d", k), {63'd0, busy_o}, 64'd0);
            chk($sformatf("vl0_tvalid_c%0d", k), {63'd0, wr_tvalid_o}, 64'd0);
        end

        // Reset while beat 2 of the long transfer is presented, then a clean transfer
        run_vec(vecs[2], 20, 1);
        @(negedge clk_i);
        #1 check_idle_outputs("post_rst");
        run_vec(vecs[0], 21, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
